butterfly_engine: RTL and testbench

Parametrised radix-2 decimation-in-time butterfly datapath with handshake I/O. It computes y = a + w·b and z = a − w·b on complex fixed-point samples, and supports a conjugate-twiddle (inverse transform) mode. It replaces switch/button-stepped butterfly control with a valid/ready stream interface, a single time-shared signed multiplier and an external synchronous twiddle ROM port. It sits between the sample buffer and the result store of the FFT pipeline.

---
 rtl/butterfly_engine_if.sv | 36 +++
 rtl/butterfly_engine.sv | 175 +++++++++++++++++
 tb/tb_butterfly_engine.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_engine_if.sv
// Stream, twiddle-ROM and status signals of the radix-2 butterfly engine.
// The master side is the surrounding pipeline (sample source, ROM, result sink).
interface butterfly_engine_if #(
    parameter int DW    = 8,
    parameter int TW_AW = 3,
    parameter int CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        a_re;
    logic [DW-1:0]        a_im;
    logic [DW-1:0]        b_re;
    logic [DW-1:0]        b_im;
    logic [TW_AW-1:0]     tw_idx;
    logic                 inv;
    logic [TW_AW-1:0]     tw_addr;
    logic [DW-1:0]        tw_re;
    logic [DW-1:0]        tw_im;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW+1:0]        y_re;
    logic [DW+1:0]        y_im;
    logic [DW+1:0]        z_re;
    logic [DW+1:0]        z_im;
    logic [CNT_W-1:0]     done_cnt;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, tw_idx, inv, tw_re, tw_im, out_ready,
        input  in_ready, tw_addr, out_valid, y_re, y_im, z_re, z_im, done_cnt
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, tw_idx, inv, tw_re, tw_im, out_ready,
        output in_ready, tw_addr, out_valid, y_re, y_im, z_re, z_im, done_cnt
    );
endinterface

// File: rtl/butterfly_engine.sv
// Radix-2 DIT butterfly y = a + w*b, z = a - w*b with one time-shared signed
// multiplier, an external synchronous twiddle ROM and valid/ready handshakes.
module butterfly_engine #(
    parameter int DW    = 8,
    parameter int FRAC  = DW - 1,
    parameter int TW_AW = 3,
    parameter int CNT_W = 16
) (
    input  logic              Clock,
    input  logic              nReset,
    butterfly_engine_if.slave bus
);
    localparam int ACC_W = 2 * DW + 2;
    localparam int OW    = DW + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        MUL_RR = 3'd2,
        MUL_II = 3'd3,
        MUL_RI = 3'd4,
        MUL_IR = 3'd5,
        SUM    = 3'd6,
        OUT    = 3'd7
    } state_t;

    state_t                   state_r;
    logic signed [DW-1:0]     a_re_r, a_im_r, b_re_r, b_im_r;
    logic                     inv_r;
    logic [TW_AW-1:0]         tw_addr_r;
    logic signed [DW:0]       tw_re_r, wi_eff_r;
    logic signed [ACC_W-1:0]  p_re_r, p_im_r;
    logic [OW-1:0]            y_re_r, y_im_r, z_re_r, z_im_r;
    logic                     out_valid_r;
    logic [CNT_W-1:0]         done_cnt_r;

    logic signed [DW:0]       tw_re_in_s, tw_im_in_s, wi_next_s;
    logic signed [DW-1:0]     mul_a_s;
    logic signed [DW:0]       mul_b_s;
    logic signed [ACC_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]  a_re_sh_s, a_im_sh_s;
    logic signed [ACC_W-1:0]  y_re_full_s, y_im_full_s, z_re_full_s, z_im_full_s;

    // Twiddle widened by one bit so that conjugating -2^(DW-1) stays exact.
    assign tw_re_in_s = $signed({bus.tw_re[DW-1], bus.tw_re});
    assign tw_im_in_s = $signed({bus.tw_im[DW-1], bus.tw_im});
    assign wi_next_s  = inv_r ? -tw_im_in_s : tw_im_in_s;

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_a_s = {DW{1'b0}};
        mul_b_s = {(DW+1){1'b0}};
        case (state_r)
            MUL_RR: begin
                mul_a_s = b_re_r;
                mul_b_s = tw_re_in_s;
            end
            MUL_II: begin
                mul_a_s = b_im_r;
                mul_b_s = wi_eff_r;
            end
            MUL_RI: begin
                mul_a_s = b_re_r;
                mul_b_s = wi_eff_r;
            end
            MUL_IR: begin
                mul_a_s = b_im_r;
                mul_b_s = tw_re_r;
            end
            default: begin
                mul_a_s = {DW{1'b0}};
                mul_b_s = {(DW+1){1'b0}};
            end
        endcase
    end

    assign prod_s = $signed({{(ACC_W-DW){mul_a_s[DW-1]}}, mul_a_s})
                  * $signed({{(ACC_W-DW-1){mul_b_s[DW]}}, mul_b_s});

    // Align a to the product's fixed point, add/subtract, then floor-shift back.
    always_comb begin
        a_re_sh_s   = $signed({{(ACC_W-DW){a_re_r[DW-1]}}, a_re_r}) <<< FRAC;
        a_im_sh_s   = $signed({{(ACC_W-DW){a_im_r[DW-1]}}, a_im_r}) <<< FRAC;
        y_re_full_s = (a_re_sh_s + p_re_r) >>> FRAC;
        z_re_full_s = (a_re_sh_s - p_re_r) >>> FRAC;
        y_im_full_s = (a_im_sh_s + p_im_r) >>> FRAC;
        z_im_full_s = (a_im_sh_s - p_im_r) >>> FRAC;
    end

    // Butterfly sequencer with all datapath and output registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r     <= IDLE;
            a_re_r      <= {DW{1'b0}};
            a_im_r      <= {DW{1'b0}};
            b_re_r      <= {DW{1'b0}};
            b_im_r      <= {DW{1'b0}};
            inv_r       <= 1'b0;
            tw_addr_r   <= {TW_AW{1'b0}};
            tw_re_r     <= {(DW+1){1'b0}};
            wi_eff_r    <= {(DW+1){1'b0}};
            p_re_r      <= {ACC_W{1'b0}};
            p_im_r      <= {ACC_W{1'b0}};
            y_re_r      <= {OW{1'b0}};
            y_im_r      <= {OW{1'b0}};
            z_re_r      <= {OW{1'b0}};
            z_im_r      <= {OW{1'b0}};
            out_valid_r <= 1'b0;
            done_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_re_r    <= bus.a_re;
                        a_im_r    <= bus.a_im;
                        b_re_r    <= bus.b_re;
                        b_im_r    <= bus.b_im;
                        inv_r     <= bus.inv;
                        tw_addr_r <= bus.tw_idx;
                        state_r   <= FETCH;
                    end
                end
                FETCH: begin
                    state_r <= MUL_RR;
                end
                MUL_RR: begin
                    tw_re_r  <= tw_re_in_s;
                    wi_eff_r <= wi_next_s;
                    p_re_r   <= prod_s;
                    state_r  <= MUL_II;
                end
                MUL_II: begin
                    p_re_r  <= p_re_r - prod_s;
                    state_r <= MUL_RI;
                end
                MUL_RI: begin
                    p_im_r  <= prod_s;
                    state_r <= MUL_IR;
                end
                MUL_IR: begin
                    p_im_r  <= p_im_r + prod_s;
                    state_r <= SUM;
                end
                SUM: begin
                    y_re_r      <= y_re_full_s[OW-1:0];
                    y_im_r      <= y_im_full_s[OW-1:0];
                    z_re_r      <= z_re_full_s[OW-1:0];
                    z_im_r      <= z_im_full_s[OW-1:0];
                    out_valid_r <= 1'b1;
                    state_r     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        done_cnt_r  <= done_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.tw_addr   = tw_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.y_re      = y_re_r;
    assign bus.y_im      = y_im_r;
    assign bus.z_re      = z_re_r;
    assign bus.z_im      = z_im_r;
    assign bus.done_cnt  = done_cnt_r;
endmodule

// File: tb/tb_butterfly_engine.sv
// Self-checking bench for butterfly_engine: directed cases, randomized butterflies
// against an integer reference model, backpressure, counter wrap and mid-run reset.
module tb_butterfly_engine;
    localparam int DW = 8;

    logic Clock;
    logic nReset;

    butterfly_engine_if #(.DW(DW), .TW_AW(3), .CNT_W(16)) bus ();
    butterfly_engine_if #(.DW(DW), .TW_AW(3), .CNT_W(2))  bus2 ();

    butterfly_engine #(.DW(DW), .FRAC(DW-1), .TW_AW(3), .CNT_W(16)) dut (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (bus.slave)
    );

    butterfly_engine #(.DW(DW), .FRAC(DW-1), .TW_AW(3), .CNT_W(2)) dut2 (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (bus2.slave)
    );

    // The narrow-counter instance sees exactly the same traffic.
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.a_re      = bus.a_re;
    assign bus2.a_im      = bus.a_im;
    assign bus2.b_re      = bus.b_re;
    assign bus2.b_im      = bus.b_im;
    assign bus2.tw_idx    = bus.tw_idx;
    assign bus2.inv       = bus.inv;
    assign bus2.out_ready = bus.out_ready;

    int rom_re [8] = '{127,  90,    0, -90, -128, -128,   0, 90};
    int rom_im [8] = '{  0, -90, -128, -90,    0, -128, 127, 90};

    // Synchronous twiddle ROMs: data appears one cycle after the address.
    always @(posedge Clock) begin
        bus.tw_re  <= 8'(rom_re[bus.tw_addr]);
        bus.tw_im  <= 8'(rom_im[bus.tw_addr]);
        bus2.tw_re <= 8'(rom_re[bus2.tw_addr]);
        bus2.tw_im <= 8'(rom_im[bus2.tw_addr]);
    end

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;
    int exp_yr, exp_yi, exp_zr, exp_zi;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div128(input int x);
        int q;
        q = x / 128;
        if ((x < 0) && ((x % 128) != 0)) q = q - 1;
        return q;
    endfunction

    function automatic int wrap10(input int v);
        int r;
        r = v & 1023;
        if (r >= 512) r = r - 1024;
        return r;
    endfunction

    // Reference: complex multiply with Q1.7 twiddle, then a +/- w*b floored.
    task automatic model(input int ar, input int ai, input int br, input int bi,
                         input int idx, input int inv_i);
        int wr, wi, pr, pi;
        wr = rom_re[idx];
        wi = inv_i ? -rom_im[idx] : rom_im[idx];
        pr = br * wr - bi * wi;
        pi = br * wi + bi * wr;
        exp_yr = wrap10(floor_div128(ar * 128 + pr));
        exp_zr = wrap10(floor_div128(ar * 128 - pr));
        exp_yi = wrap10(floor_div128(ai * 128 + pi));
        exp_zi = wrap10(floor_div128(ai * 128 - pi));
    endtask

    task automatic check_outs(input string tag);
        int v;
        v = $signed(bus.y_re); check_eq({tag, ".y_re"}, v, exp_yr);
        v = $signed(bus.y_im); check_eq({tag, ".y_im"}, v, exp_yi);
        v = $signed(bus.z_re); check_eq({tag, ".z_re"}, v, exp_zr);
        v = $signed(bus.z_im); check_eq({tag, ".z_im"}, v, exp_zi);
    endtask

    task automatic accept(input int ar, input int ai, input int br, input int bi,
                          input int idx, input int inv_i);
        int w;
        bus.a_re     = 8'(ar);
        bus.a_im     = 8'(ai);
        bus.b_re     = 8'(br);
        bus.b_im     = 8'(bi);
        bus.tw_idx   = 3'(idx);
        bus.inv      = 1'(inv_i);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 40) begin
            @(posedge Clock); #1;
            w++;
        end
        check_eq("accept_wait", int'(bus.in_ready), 1);
        @(posedge Clock); #1;
        model(ar, ai, br, bi, idx, inv_i);
        bus.in_valid = 1'b0;
        bus.a_re     = 8'($urandom);
        bus.a_im     = 8'($urandom);
        bus.b_re     = 8'($urandom);
        bus.b_im     = 8'($urandom);
        bus.tw_idx   = 3'($urandom);
        bus.inv      = ~bus.inv;
    endtask

    task automatic collect(input string tag, input int hold_low);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
            if (lat == 3) check_eq({tag, ".busy_in_ready"}, int'(bus.in_ready), 0);
        end
        check_eq({tag, ".latency"}, lat, 6);
        for (int i = 0; i < hold_low; i++) begin
            check_outs({tag, ".hold"});
            check_eq({tag, ".hold_in_ready"}, int'(bus.in_ready), 0);
            @(posedge Clock); #1;
        end
        check_outs(tag);
        check_eq({tag, ".out_valid"}, int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        @(posedge Clock); #1;
        bus.out_ready = 1'b0;
        model_cnt++;
        check_eq({tag, ".ov_drop"}, int'(bus.out_valid), 0);
        check_eq({tag, ".in_ready_back"}, int'(bus.in_ready), 1);
        check_eq({tag, ".done_cnt"}, int'(bus.done_cnt), model_cnt % 65536);
        check_eq({tag, ".done_cnt_w2"}, int'(bus2.done_cnt), model_cnt % 4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_re      = 8'd0;
        bus.a_im      = 8'd0;
        bus.b_re      = 8'd0;
        bus.b_im      = 8'd0;
        bus.tw_idx    = 3'd0;
        bus.inv       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_eq("rst.in_ready", int'(bus.in_ready), 1);
        check_eq("rst.out_valid", int'(bus.out_valid), 0);
        check_eq("rst.tw_addr", int'(bus.tw_addr), 0);
        check_eq("rst.y_re", int'(bus.y_re), 0);
        check_eq("rst.z_im", int'(bus.z_im), 0);
        check_eq("rst.done_cnt", int'(bus.done_cnt), 0);
        #4 nReset = 1'b1;
        @(posedge Clock); #1;

        accept(10, 0, 64, 0, 0, 0);
        check_eq("real.exp_y_re", exp_yr, 73);
        check_eq("real.exp_z_re", exp_zr, -54);
        collect("real", 0);
        accept(0, 0, 32, 16, 2, 0);
        collect("minus_j", 1);
        accept(0, 0, 32, 16, 2, 1);
        collect("inverse", 0);
        accept(-128, -128, -128, -128, 5, 0);
        collect("extreme", 2);

        // Second request waits upstream while the first is held by backpressure.
        accept(37, -20, 100, -77, 1, 0);
        bus.a_re = 8'd5; bus.a_im = 8'd6; bus.b_re = 8'd7; bus.b_im = 8'd8;
        bus.tw_idx = 3'd6; bus.inv = 1'b1; bus.in_valid = 1'b1;
        collect("b2b_first", 5);
        accept(5, 6, 7, 8, 6, 1);
        collect("b2b_second", 0);

        for (int n = 0; n < 24; n++) begin
            accept($signed(8'($urandom)), $signed(8'($urandom)),
                   $signed(8'($urandom)), $signed(8'($urandom)),
                   int'($urandom_range(7, 0)), int'($urandom_range(1, 0)));
            collect("rand", int'($urandom_range(3, 0)));
        end

        // Abandon a butterfly while it sits in MUL_RI.
        accept(50, 50, 50, 50, 7, 0);
        repeat (3) begin
            @(posedge Clock); #1;
        end
        nReset = 1'b0;
        #1;
        model_cnt = 0;
        check_eq("midrst.in_ready", int'(bus.in_ready), 1);
        check_eq("midrst.out_valid", int'(bus.out_valid), 0);
        check_eq("midrst.done_cnt", int'(bus.done_cnt), 0);
        #3 nReset = 1'b1;
        @(posedge Clock); #1;
        accept(-3, 9, 120, -45, 3, 1);
        collect("after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
